// File: rtl/tt_dpll_lock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tt_dpll_lock_ctrl                                            |
// | Description : DPLL acquisition and lock sequencer. Steps the loop through  |
// |               integrator clear, high-gain acquire, low-gain track and lock |
// |               monitoring, with counted and hysteretic lock detection.      |
// | Options     : TT_DPLL_LOCK_CTRL_TIMEOUT_EN adds a TRACK timeout that       |
// |               restarts acquisition when lock is not reached in time.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tt_dpll_lock_ctrl #(
    parameter int GAIN_W         = 4,
    parameter int ACQ_GAIN       = 8,
    parameter int TRK_GAIN       = 2,
    parameter int ACQ_CYCLES     = 256,
    parameter int LOCK_CNT       = 64,
    parameter int UNLOCK_CNT     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_up,
    input  logic              i_down,
    output logic              o_lpf_clear,
    output logic [GAIN_W-1:0] o_gain,
    output logic [2:0]        o_state,
    output logic              o_locked,
    output logic [7:0]        o_relock_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    // Integrator clear is held for a fixed two cycles.
    localparam int c_clr_cycles = 2;
    localparam int c_clr_w      = $clog2(c_clr_cycles + 1);
    localparam int c_acq_w      = $clog2(ACQ_CYCLES + 1);
    localparam int c_lock_w     = $clog2(LOCK_CNT + 1);
    localparam int c_unlock_w   = $clog2(UNLOCK_CNT + 1);

    // Terminal values: a transition fires on the edge where the counter
    // would step from "last" to the full count.
    localparam logic [c_clr_w-1:0]    c_clr_last    = c_clr_w'(c_clr_cycles - 1);
    localparam logic [c_acq_w-1:0]    c_acq_last    = c_acq_w'(ACQ_CYCLES - 1);
    localparam logic [c_lock_w-1:0]   c_lock_last   = c_lock_w'(LOCK_CNT - 1);
    localparam logic [c_unlock_w-1:0] c_unlock_last = c_unlock_w'(UNLOCK_CNT - 1);
    localparam logic [GAIN_W-1:0]     c_acq_gain    = GAIN_W'(ACQ_GAIN);
    localparam logic [GAIN_W-1:0]     c_trk_gain    = GAIN_W'(TRK_GAIN);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_clr_w-1:0]      r_clr_cnt;
    logic [c_acq_w-1:0]      r_acq_cnt;
    logic [c_lock_w-1:0]     r_quiet_cnt;
    logic [c_unlock_w-1:0]   r_active_cnt;
    logic [7:0]              r_relock_cnt;
    logic                    w_quiet;
    logic                    w_relock_evt;
    logic                    w_timeout;
    logic                    w_cnt_clear;

    // Both PFD pulses together is treated as activity, not as quiet.
    assign w_quiet = !i_up && !i_down;

    // Every counter restarts on any state change and while disabled.
    assign w_cnt_clear = (w_state_next != r_state) || !i_enable;

`ifdef TT_DPLL_LOCK_CTRL_TIMEOUT_EN
    localparam int                 c_trk_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_trk_w-1:0] c_trk_last = c_trk_w'(TIMEOUT_CYCLES - 1);

    logic [c_trk_w-1:0] r_trk_cnt;

    // Counts cycles spent in TRACK since entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trk_cnt <= '0;
        end else if (w_cnt_clear) begin
            r_trk_cnt <= '0;
        end else if (r_state == ST_TRACK) begin
            r_trk_cnt <= r_trk_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_trk_cnt == c_trk_last);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a disable request overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        w_relock_evt = 1'b0;
        if (!i_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == c_clr_last) begin
                        w_state_next = ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (r_acq_cnt == c_acq_last) begin
                        w_state_next = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // Lock qualification wins over a coincident timeout.
                    if (w_quiet && (r_quiet_cnt == c_lock_last)) begin
                        w_state_next = ST_LOCKED;
                    end else if (w_timeout) begin
                        w_state_next = ST_CLEAR;
                        w_relock_evt = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_quiet && (r_active_cnt == c_unlock_last)) begin
                        w_state_next = ST_CLEAR;
                        w_relock_evt = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Per-state dwell, quiet and active counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt    <= '0;
            r_acq_cnt    <= '0;
            r_quiet_cnt  <= '0;
            r_active_cnt <= '0;
        end else if (w_cnt_clear) begin
            r_clr_cnt    <= '0;
            r_acq_cnt    <= '0;
            r_quiet_cnt  <= '0;
            r_active_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR:   r_clr_cnt <= r_clr_cnt + 1'b1;
                ST_ACQUIRE: r_acq_cnt <= r_acq_cnt + 1'b1;
                ST_TRACK:   r_quiet_cnt  <= w_quiet ? r_quiet_cnt + 1'b1 : '0;
                ST_LOCKED:  r_active_cnt <= w_quiet ? '0 : r_active_cnt + 1'b1;
                default:    ;
            endcase
        end
    end

    // Saturating count of lock losses and timeouts; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_relock_cnt <= 8'd0;
        end else if (w_relock_evt && (r_relock_cnt != 8'hFF)) begin
            r_relock_cnt <= r_relock_cnt + 8'd1;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        o_lpf_clear = 1'b0;
        o_gain      = '0;
        o_locked    = 1'b0;
        case (r_state)
            ST_CLEAR:   o_lpf_clear = 1'b1;
            ST_ACQUIRE: o_gain      = c_acq_gain;
            ST_TRACK:   o_gain      = c_trk_gain;
            ST_LOCKED: begin
                o_gain   = c_trk_gain;
                o_locked = 1'b1;
            end
            default:    ;
        endcase
    end

    assign o_state      = r_state;
    assign o_relock_cnt = r_relock_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tt_dpll_lock_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tt_dpll_lock_ctrl                                         |
// | Description : Self-checking bench for tt_dpll_lock_ctrl: table-driven lock |
// |               acquisition plus hand-written corner-case sequences.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tt_dpll_lock_ctrl;

    localparam int ACQ    = 16;
    localparam int LOCK   = 8;
    localparam int UNLOCK = 3;
    localparam int TMO    = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic       dn    = 1'b0;
    logic       lpf_clear;
    logic [3:0] gain;
    logic [2:0] state;
    logic       locked;
    logic [7:0] relock;

    tt_dpll_lock_ctrl #(
        .GAIN_W         (4),
        .ACQ_GAIN       (8),
        .TRK_GAIN       (2),
        .ACQ_CYCLES     (ACQ),
        .LOCK_CNT       (LOCK),
        .UNLOCK_CNT     (UNLOCK),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (en),
        .i_up         (up),
        .i_down       (dn),
        .o_lpf_clear  (lpf_clear),
        .o_gain       (gain),
        .o_state      (state),
        .o_locked     (locked),
        .o_relock_cnt (relock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       up;
        logic       dn;
        logic [2:0] st;
        logic [3:0] gain;
        logic       clr;
        logic       lk;
        logic [7:0] rel;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    vec_t       sb[$];
    vec_t       tbl[30];
    logic [7:0] exp_rel;

    function automatic vec_t mk(input logic e_en, input logic e_up, input logic e_dn,
                                input logic [2:0] e_st, input logic [3:0] e_gain,
                                input logic e_clr, input logic e_lk, input logic [7:0] e_rel);
        vec_t v;
        v.en = e_en; v.up = e_up; v.dn = e_dn; v.st = e_st; v.gain = e_gain;
        v.clr = e_clr; v.lk = e_lk; v.rel = e_rel;
        return v;
    endfunction

    // Expected outputs after edge e of an all-quiet run, edge 0 being the
    // first edge sampling enable in IDLE (or the edge that entered CLEAR).
    function automatic vec_t quiet_vec(input int e, input logic [7:0] rel);
        if (e < 2)                return mk(1, 0, 0, 3'd1, 4'd0, 1, 0, rel);
        else if (e < 2 + ACQ)     return mk(1, 0, 0, 3'd2, 4'd8, 0, 0, rel);
        else if (e < 2 + ACQ + LOCK) return mk(1, 0, 0, 3'd3, 4'd2, 0, 0, rel);
        else                      return mk(1, 0, 0, 3'd4, 4'd2, 0, 1, rel);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] r);
        return (r == 8'hFF) ? 8'hFF : r + 8'd1;
    endfunction

    task automatic check_out(input string name, input vec_t e);
        n_checks++;
        if (state === e.st && gain === e.gain && lpf_clear === e.clr &&
            locked === e.lk && relock === e.rel) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d gain=%0d clr=%b lk=%b rel=%0d, want st=%0d gain=%0d clr=%b lk=%b rel=%0d",
                     name, state, gain, lpf_clear, locked, relock,
                     e.st, e.gain, e.clr, e.lk, e.rel);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        en = v.en;
        up = v.up;
        dn = v.dn;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got 0 entries want 1", name);
        end else begin
            e = sb.pop_front();
            check_out(name, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        for (int e = 0; e < 30; e++) tbl[e] = quiet_vec(e, 8'd0);

        // Reset values, asserted and just after release between edges.
        #12;
        check_out("reset_active", mk(0, 0, 0, 3'd0, 4'd0, 0, 0, 8'd0));
        #10;
        rst_n = 1'b1;
        check_out("reset_release", mk(0, 0, 0, 3'd0, 4'd0, 0, 0, 8'd0));
        @(posedge clk);
        #1;
        apply(mk(0, 0, 0, 3'd0, 4'd0, 0, 0, 8'd0), "idle_hold");

        // Quiet acquisition from IDLE through to LOCKED.
        for (int e = 0; e < 30; e++) apply(tbl[e], $sformatf("acq_seq_e%0d", e));

        // Short down burst holds lock; three both-active cycles drop it.
        exp_rel = 8'd0;
        apply(mk(1, 0, 1, 3'd4, 4'd2, 0, 1, exp_rel), "lk_down1");
        apply(mk(1, 0, 1, 3'd4, 4'd2, 0, 1, exp_rel), "lk_down2");
        apply(mk(1, 0, 0, 3'd4, 4'd2, 0, 1, exp_rel), "lk_quiet");
        apply(mk(1, 1, 1, 3'd4, 4'd2, 0, 1, exp_rel), "lk_both1");
        apply(mk(1, 1, 1, 3'd4, 4'd2, 0, 1, exp_rel), "lk_both2");
        exp_rel = sat_inc(exp_rel);
        apply(mk(1, 1, 1, 3'd1, 4'd0, 1, 0, exp_rel), "unlock");

        // Re-acquire into TRACK, then pulse up every 5 cycles.
        for (int e = 1; e <= 2 + ACQ; e++) apply(quiet_vec(e, exp_rel), $sformatf("reacq_e%0d", e));
        for (int i = 1; i <= TMO; i++) begin
            vec_t v;
            v = mk(1, (i % 5) == 0, 0, 3'd3, 4'd2, 0, 0, exp_rel);
`ifdef TT_DPLL_LOCK_CTRL_TIMEOUT_EN
            if (i == TMO) begin
                exp_rel = sat_inc(exp_rel);
                v = mk(1, 0, 0, 3'd1, 4'd0, 1, 0, exp_rel);
            end
`endif
            apply(v, $sformatf("trk_pulse_%0d", i));
        end
        apply(mk(0, 0, 0, 3'd0, 4'd0, 0, 0, exp_rel), "drop_trk");

        // Enable drop in ACQUIRE and in LOCKED; counters restart afterwards.
        for (int e = 0; e <= 6; e++) apply(quiet_vec(e, exp_rel), $sformatf("pre_drop_acq_e%0d", e));
        apply(mk(0, 0, 0, 3'd0, 4'd0, 0, 0, exp_rel), "drop_acq");
        for (int e = 0; e <= 27; e++) apply(quiet_vec(e, exp_rel), $sformatf("pre_drop_lk_e%0d", e));
        apply(mk(0, 0, 0, 3'd0, 4'd0, 0, 0, exp_rel), "drop_lock");
        for (int e = 0; e <= 26; e++) apply(quiet_vec(e, exp_rel), $sformatf("relock_e%0d", e));
        apply(mk(0, 0, 0, 3'd0, 4'd0, 0, 0, exp_rel), "drop_lock2");

        // Asynchronous reset between edges while in TRACK.
        for (int e = 0; e <= 20; e++) apply(quiet_vec(e, exp_rel), $sformatf("pre_rst_e%0d", e));
        #3;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid_track", mk(1, 0, 0, 3'd0, 4'd0, 0, 0, 8'd0));
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_rel = 8'd0;
        apply(mk(0, 0, 0, 3'd0, 4'd0, 0, 0, exp_rel), "post_rst_idle");

        // 256 lock losses to saturate the relock counter.
        for (int n = 0; n < 256; n++) begin
            for (int e = (n == 0) ? 0 : 1; e <= 2 + ACQ + LOCK; e++)
                apply(quiet_vec(e, exp_rel), $sformatf("sat%0d_e%0d", n, e));
            for (int b = 1; b < UNLOCK; b++)
                apply(mk(1, 1, 1, 3'd4, 4'd2, 0, 1, exp_rel), $sformatf("sat%0d_act%0d", n, b));
            exp_rel = sat_inc(exp_rel);
            apply(mk(1, 1, 1, 3'd1, 4'd0, 1, 0, exp_rel), $sformatf("sat%0d_loss", n));
        end
        n_checks++;
        if (relock === 8'd255) n_pass++;
        else $display("FAIL relock_saturate: got %0d want 255", relock);
        apply(mk(0, 0, 0, 3'd0, 4'd0, 0, 0, 8'd255), "final_drop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
